// File: rtl/neuron_sequencer.sv
// Sequencer for one chunked dot-product inference with running argmax.
// Ports: clk/rst, start/busy/done, mem_en/mem_addr, bias_sel/acc_load/acc_en,
//   acc_dout, score_valid/score_idx, class_out/class_score.
//   Optional macro REJECT_THRESH_EN enables a reject threshold.
module neuron_sequencer #(
  parameter int NUM_NEURONS = 10,
  parameter int CHUNKS      = 4,
  parameter int PIPE_LAT    = 4,
  parameter int ADDR_W      = 8,
  parameter int ACC_W       = 22,
  parameter int CLS_W       = 4
`ifdef REJECT_THRESH_EN
  ,
  parameter logic signed [ACC_W-1:0] REJECT_THRESH = '0
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [CLS_W-1:0]        bias_sel,
  output logic                    acc_load,
  output logic                    acc_en,
  input  logic signed [ACC_W-1:0] acc_dout,
  output logic                    score_valid,
  output logic [CLS_W-1:0]        score_idx,
  output logic [CLS_W-1:0]        class_out,
  output logic signed [ACC_W-1:0] class_score
);

  localparam int TOTAL = NUM_NEURONS * CHUNKS;
  localparam int CHK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic             v;
    logic             first;
    logic             last;
    logic [CLS_W-1:0] n;
  } tag_t;

  state_t state, nxt_state;

  logic [ADDR_W-1:0] nxt_addr;
  logic [CHK_W-1:0]  nxt_chk;
  logic [CLS_W-1:0]  nxt_nrn;
  tag_t              pipe [PIPE_LAT];
  tag_t              new_tag;

  logic              tap_last;
  logic              cap_pend;
  logic [CLS_W-1:0]  cap_n;
  logic signed [ACC_W-1:0] score_reg;

  logic              have_max;
  logic signed [ACC_W-1:0] max_val;
  logic [CLS_W-1:0]  max_idx;

  logic              issue;
  logic              last_iss;
  logic              upd;
  logic signed [ACC_W-1:0] win_val;
  logic [CLS_W-1:0]  win_idx;
  logic [CLS_W-1:0]  fin_idx;

  assign last_iss = (nxt_addr == ADDR_W'(TOTAL - 1));
  assign issue = ((state == S_IDLE) && start)
              || (state == S_ISSUE);
  assign busy = (state != S_IDLE);

  assign new_tag.v     = 1'b1;
  assign new_tag.first = (nxt_chk == '0);
  assign new_tag.last  = (nxt_chk == CHK_W'(CHUNKS - 1));
  assign new_tag.n     = nxt_nrn;

  // The first score seeds the max; later ones need a strict win,
  // so equal scores keep the lower index.
  assign upd = !have_max || (score_reg > max_val);
  assign win_val = upd ? score_reg : max_val;
  assign win_idx = upd ? score_idx : max_idx;

`ifdef REJECT_THRESH_EN
  assign fin_idx = (win_val < REJECT_THRESH) ? '1 : win_idx;
`else
  assign fin_idx = win_idx;
`endif

  always_comb begin
    nxt_state = state;
    unique case (state)
      S_IDLE:
        if (start) nxt_state = last_iss ? S_DRAIN : S_ISSUE;
      S_ISSUE:
        if (last_iss) nxt_state = S_DRAIN;
      S_DRAIN:
        if (cap_pend && cap_n == CLS_W'(NUM_NEURONS - 1))
          nxt_state = S_DONE;
      S_DONE:
        nxt_state = S_IDLE;
      default:
        nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      nxt_addr <= '0;
      nxt_chk  <= '0;
      nxt_nrn  <= '0;
    end else begin
      state  <= nxt_state;
      mem_en <= issue;
      if (issue) begin
        mem_addr <= nxt_addr;
        if (last_iss) begin
          nxt_addr <= '0;
          nxt_chk  <= '0;
          nxt_nrn  <= '0;
        end else begin
          nxt_addr <= nxt_addr + 1'b1;
          if (nxt_chk == CHK_W'(CHUNKS - 1)) begin
            nxt_chk <= '0;
            nxt_nrn <= nxt_nrn + 1'b1;
          end else begin
            nxt_chk <= nxt_chk + 1'b1;
          end
        end
      end
    end
  end

  // Tag pipe tracks each address through the multiply latency;
  // the output strobes form the final stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
      acc_load <= 1'b0;
      acc_en   <= 1'b0;
      bias_sel <= '0;
      tap_last <= 1'b0;
    end else begin
      pipe[0] <= issue ? new_tag : '0;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
      acc_load <= pipe[PIPE_LAT-1].v & pipe[PIPE_LAT-1].first;
      acc_en   <= pipe[PIPE_LAT-1].v & ~pipe[PIPE_LAT-1].first;
      tap_last <= pipe[PIPE_LAT-1].v & pipe[PIPE_LAT-1].last;
      if (pipe[PIPE_LAT-1].v) bias_sel <= pipe[PIPE_LAT-1].n;
    end
  end

  // acc_dout settles one cycle after the last add, hence cap_pend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_pend    <= 1'b0;
      cap_n       <= '0;
      score_valid <= 1'b0;
      score_idx   <= '0;
      score_reg   <= '0;
    end else begin
      cap_pend    <= tap_last;
      score_valid <= cap_pend;
      if (tap_last) cap_n <= bias_sel;
      if (cap_pend) begin
        score_idx <= cap_n;
        score_reg <= acc_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      have_max    <= 1'b0;
      max_val     <= '0;
      max_idx     <= '0;
      done        <= 1'b0;
      class_out   <= '0;
      class_score <= '0;
    end else begin
      done <= (state == S_DONE);
      if (score_valid) begin
        have_max <= 1'b1;
        max_val  <= win_val;
        max_idx  <= win_idx;
      end
      if (state == S_DONE) begin
        have_max    <= 1'b0;
        class_out   <= fin_idx;
        class_score <= win_val;
      end
    end
  end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
- Controller that runs the chunked dot-product datapath for one inference: pixel/weight memory → pipeline1 → acc.
- Issues chunk addresses and aligns accumulator load/enable strobes with the multiply pipeline latency.
- Captures one score per neuron and tracks a running signed argmax.
- Reports the predicted class with a start/busy/done handshake; this replaces hand-timed testbench sequencing.

Parameters:
- NUM_NEURONS, 10, output neurons (classes) per inference.
- CHUNKS, 4, 128-bit chunks per neuron.
- PIPE_LAT, 4, cycles from address issue to valid partial sum s at acc input.
- ADDR_W, 8, chunk address width; must satisfy 2^ADDR_W ≥ NUM_NEURONS*CHUNKS.
- ACC_W, 22, accumulator output width (signed).
- CLS_W, 4, class index width.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, request one inference; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when class_out is valid.
- mem_en, output, 1, chunk read strobe to the pixel and weight memories.
- mem_addr, output, ADDR_W, chunk address (neuron*CHUNKS + chunk).
- bias_sel, output, CLS_W, neuron index whose bias the acc loads.
- acc_load, output, 1, acc loads bias + s (first chunk of a neuron).
- acc_en, output, 1, acc adds s (remaining chunks).
- acc_dout, input, ACC_W, signed acc result, valid 1 cycle after the last acc_en of a neuron.
- score_valid, output, 1, pulse when acc_dout is captured.
- score_idx, output, CLS_W, neuron index of the captured score.
- class_out, output, CLS_W, argmax neuron index; held until the next start.
- class_score, output, ACC_W, winning score; held with class_out.

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; issue counter, tag pipe and max registers cleared. Reset mid-inference aborts immediately with no done pulse.
- FSM: IDLE → ISSUE on start=1. ISSUE → DRAIN after address NUM_NEURONS*CHUNKS-1 is issued. DRAIN → DONE when the last score is captured. DONE → IDLE unconditionally after 1 cycle.
- ISSUE: mem_en=1 every cycle; mem_addr counts 0..NUM_NEURONS*CHUNKS-1 contiguously with no bubbles. First address appears the cycle after start is sampled.
- Tag pipe: a PIPE_LAT-deep shift register carries {valid, first, last, neuron} for each issued address.
- At the tap: acc_load = valid&first; acc_en = valid&!first; bias_sel = tagged neuron. acc_load and acc_en are never high together.
- Score capture: one cycle after a tap with valid&last, the block registers acc_dout and pulses score_valid with score_idx = neuron.
- Argmax: the first score of an inference unconditionally initialises max. Each later score replaces max only if strictly greater (signed), so ties keep the lower index.
- Completion: done and the class_out/class_score update occur in the same cycle, NUM_NEURONS*CHUNKS + PIPE_LAT + 2 cycles after the start-sampling edge (46 at defaults). busy falls in that same cycle.
- start while busy or in DONE: ignored, never queued.
- mem_addr holds its last value when mem_en=0.
- class_out/class_score keep the previous result until a new done.

Optional Feature:
- Macro REJECT_THRESH_EN adds parameter REJECT_THRESH (signed, ACC_W bits, default 0).
- When defined: if the final max score < REJECT_THRESH, class_out is all-ones (4'hF, reject); class_score still reports the max.
- When undefined: no comparator and no reject code; class_out is always a neuron index.

Test Plan:
- Reset then idle: rst=0 mid-run at cycle 20 → all outputs 0 next cycle; no done; a fresh start afterwards completes normally in 46 cycles.
- Single inference, acc model with PIPE_LAT=4, scores {5,-3,9,2,0,1,7,8,-1,4} → score_valid ×10 with score_idx 0..9 in order; done at cycle 46; class_out=2; class_score=9.
- Strobe alignment: check acc_load at taps for addr 0,4,...,36 and acc_en at the other 30 taps; bias_sel matches addr/4; mem_addr 0..39 contiguous.
- Tie and negative: all scores -7 → class_out=0, class_score=-7 (22'h3FFFF9); equal max at idx 3 and 6 → class_out=3.
- start pulsed at cycles 10 and 45 during a run → ignored; start at cycle 47 (IDLE) → second run; class_out holds the old value until the second done.
- REJECT_THRESH_EN, REJECT_THRESH=10, max=9 → class_out=4'hF, class_score=9; macro undefined → class_out=2.
